// File: rtl/programmable_reflector_if.sv
// Handshake bundle for the programmable reflector: wiring
// configuration channel plus the valid/ready lookup path.
interface programmable_reflector_if #(
    parameter int W = 5
);
    logic         cfg_start;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_a;
    logic [W-1:0] cfg_b;
    logic         cfg_err;
    logic         armed;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_sym;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sym;
    logic         out_err;

    modport master (
        output cfg_start, cfg_valid, cfg_a, cfg_b,
        output in_valid, in_sym, out_ready,
        input  cfg_ready, cfg_err, armed,
        input  in_ready, out_valid, out_sym, out_err
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_a, cfg_b,
        input  in_valid, in_sym, out_ready,
        output cfg_ready, cfg_err, armed,
        output in_ready, out_valid, out_sym, out_err
    );
endinterface

// File: rtl/programmable_reflector.sv
// Rewirable reflector: runtime-loaded involution table with
// pairwise validated loading and a registered lookup stage.
module programmable_reflector #(
    parameter int N = 26,
    parameter int W = 5
) (
    input logic                     clk,
    input logic                     rst,
    programmable_reflector_if.slave bus
);
    localparam int P  = N / 2;
    localparam int CW = $clog2(P + 1);
    localparam logic [W:0]    NL = (W+1)'(N);
    localparam logic [CW-1:0] PL = CW'(P);

    typedef enum logic { ARMED, LOADING } state_t;

    state_t        state;
    state_t        state_nx;
    logic [W-1:0]  tbl [N];
    logic [N-1:0]  paired;
    logic [CW-1:0] pair_count;
    logic          cfg_err_q;
    logic          live;
    logic          out_valid_q;
    logic [W-1:0]  out_sym_q;
    logic          out_err_q;

    logic a_in;
    logic b_in;
    logic s_in;
    logic a_used;
    logic b_used;
    logic wr;
    logic legal;
    logic last;
    logic in_ready;
    logic accept;

    assign a_in   = {1'b0, bus.cfg_a} < NL;
    assign b_in   = {1'b0, bus.cfg_b} < NL;
    assign s_in   = {1'b0, bus.in_sym} < NL;
    // Out-of-range symbols count as already used so they are rejected
    assign a_used = a_in ? paired[bus.cfg_a] : 1'b1;
    assign b_used = b_in ? paired[bus.cfg_b] : 1'b1;

    assign wr    = bus.cfg_valid && (state == LOADING) && !bus.cfg_start;
    assign legal = (bus.cfg_a != bus.cfg_b) && !a_used && !b_used;
    assign last  = wr && legal && !cfg_err_q
                && (pair_count == PL - CW'(1));

    // live holds lookups off until the first clock after reset
    assign in_ready = (state == ARMED) && live
                   && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign bus.armed     = (state == ARMED);
    assign bus.cfg_ready = (state == LOADING);
    assign bus.cfg_err   = cfg_err_q;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_err   = out_err_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARMED;
        else     state <= state_nx;
    end

    // Next state: cfg_start always wins, arm on the completing pair
    always_comb begin
        state_nx = state;
        if (bus.cfg_start) state_nx = LOADING;
        else if (last)     state_nx = ARMED;
    end

    // Wiring table, pairing bookkeeping and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) tbl[i] <= W'(N - 1 - i);
            paired     <= '1;
            pair_count <= PL;
            cfg_err_q  <= 1'b0;
        end else if (bus.cfg_start) begin
            paired     <= '0;
            pair_count <= '0;
            cfg_err_q  <= 1'b0;
        end else if (wr) begin
            if (!legal) begin
                cfg_err_q <= 1'b1;
            end else begin
                tbl[bus.cfg_a]    <= bus.cfg_b;
                tbl[bus.cfg_b]    <= bus.cfg_a;
                paired[bus.cfg_a] <= 1'b1;
                paired[bus.cfg_b] <= 1'b1;
                pair_count        <= pair_count + CW'(1);
            end
        end
    end

    // Lookup output register with valid/ready hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live        <= 1'b0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_sym_q   <= s_in ? tbl[bus.in_sym] : bus.in_sym;
                out_err_q   <= !s_in;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_programmable_reflector.sv
// Self-checking bench: directed plan plus random traffic,
// scored every cycle against a behavioural model.
module tb_programmable_reflector;
    localparam int N = 26;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst;

    programmable_reflector_if #(.W(W)) bus ();

    programmable_reflector #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model: the observable state after the last edge
    int m_tbl [N];
    bit m_paired [N];
    int m_cnt;
    bit m_err;
    bit m_armed;
    bit m_live;
    bit m_ov;
    int m_os;
    bit m_oe;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_tbl[i]    = N - 1 - i;
            m_paired[i] = 1'b1;
        end
        m_cnt   = N / 2;
        m_err   = 1'b0;
        m_armed = 1'b1;
        m_live  = 1'b0;
        m_ov    = 1'b0;
        m_os    = 0;
        m_oe    = 1'b0;
    endfunction

    // Compare against the model, then advance it over the coming edge
    always @(negedge clk) begin
        automatic bit rdy;
        automatic bit acc;
        automatic int s;
        automatic int a;
        automatic int b;
        automatic int res;
        if (rst) model_reset();
        rdy = m_armed && m_live && (!m_ov || bus.out_ready);
        chk("armed", int'(bus.armed), int'(m_armed));
        chk("cfg_ready", int'(bus.cfg_ready), int'(!m_armed));
        chk("in_ready", int'(bus.in_ready), int'(rdy));
        chk("cfg_err", int'(bus.cfg_err), int'(m_err));
        chk("out_valid", int'(bus.out_valid), int'(m_ov));
        if (m_ov || rst) begin
            chk("out_sym", int'(bus.out_sym), m_os);
            chk("out_err", int'(bus.out_err), int'(m_oe));
        end
        if (!rst) begin
            acc = bus.in_valid && rdy;
            s   = int'(bus.in_sym);
            res = (s < N) ? m_tbl[s] : s;
            if (bus.cfg_start) begin
                m_armed = 1'b0;
                m_err   = 1'b0;
                m_cnt   = 0;
                for (int i = 0; i < N; i++) m_paired[i] = 1'b0;
            end else if (!m_armed && bus.cfg_valid) begin
                a = int'(bus.cfg_a);
                b = int'(bus.cfg_b);
                if (a >= N || b >= N || a == b || m_paired[a] || m_paired[b]) begin
                    m_err = 1'b1;
                end else begin
                    m_tbl[a] = b;
                    m_tbl[b] = a;
                    m_paired[a] = 1'b1;
                    m_paired[b] = 1'b1;
                    m_cnt++;
                    if (m_cnt == N / 2 && !m_err) m_armed = 1'b1;
                end
            end
            if (acc) begin
                m_ov = 1'b1;
                m_os = res;
                m_oe = (s >= N);
            end else if (bus.out_ready) begin
                m_ov = 1'b0;
            end
            m_live = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_a     = '0;
        bus.cfg_b     = '0;
        bus.in_valid  = 1'b0;
        bus.in_sym    = '0;
        bus.out_ready = 1'b1;
    endtask

    task automatic pulse_start();
        bus.cfg_start = 1'b1;
        cyc();
        bus.cfg_start = 1'b0;
    endtask

    task automatic put_pair(input int a, input int b);
        bus.cfg_valid = 1'b1;
        bus.cfg_a     = W'(a);
        bus.cfg_b     = W'(b);
        cyc();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic lookup(input int s, input int exp, input string nm);
        bus.in_valid = 1'b1;
        bus.in_sym   = W'(s);
        cyc();
        bus.in_valid = 1'b0;
        chk(nm, int'(bus.out_sym), exp);
    endtask

    initial begin
        int free [$];
        int i0;
        int i1;
        rst = 1'b1;
        idle();
        repeat (2) cyc();
        chk("rst_armed", int'(bus.armed), 1);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        rst = 1'b0;
        cyc();
        chk("first_in_ready", int'(bus.in_ready), 1);

        // Mirror lookups back to back
        bus.in_valid = 1'b1;
        bus.in_sym = W'(0);
        cyc();
        chk("mir0", int'(bus.out_sym), 25);
        bus.in_sym = W'(7);
        cyc();
        chk("mir7", int'(bus.out_sym), 18);
        bus.in_sym = W'(25);
        cyc();
        chk("mir25", int'(bus.out_sym), 0);
        chk("mir25_err", int'(bus.out_err), 0);
        bus.in_valid = 1'b0;
        cyc();

        // Full adjacent-pair load
        pulse_start();
        for (int k = 0; k < 12; k++) put_pair(2 * k, 2 * k + 1);
        chk("arm_before_13", int'(bus.armed), 0);
        put_pair(24, 25);
        chk("arm_after_13", int'(bus.armed), 1);
        lookup(4, 5, "adj4");
        lookup(25, 24, "adj25");
        cyc();

        // Illegal pairs latch the error and block arming
        pulse_start();
        put_pair(0, 1);
        chk("err_after_1", int'(bus.cfg_err), 0);
        put_pair(1, 5);
        chk("err_after_2", int'(bus.cfg_err), 1);
        put_pair(3, 3);
        put_pair(30, 2);
        for (int k = 1; k < 13; k++) put_pair(2 * k, 2 * k + 1);
        cyc();
        chk("err_no_arm", int'(bus.armed), 0);
        pulse_start();
        chk("err_cleared", int'(bus.cfg_err), 0);

        // Back to mirror, then backpressure hold
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sym = W'(0);
        cyc();
        bus.in_sym = W'(3);
        for (int k = 0; k < 5; k++) begin
            chk("hold_ready", int'(bus.in_ready), 0);
            chk("hold_sym", int'(bus.out_sym), 25);
            cyc();
        end
        bus.out_ready = 1'b1;
        cyc();
        chk("release_sym", int'(bus.out_sym), 22);
        bus.in_valid = 1'b0;

        // Out-of-range lookup and result pending across cfg_start
        lookup(27, 27, "oor_sym");
        chk("oor_err", int'(bus.out_err), 1);
        lookup(1, 24, "pend_sym");
        bus.out_ready = 1'b0;
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            chk("pend_ready", int'(bus.in_ready), 0);
            chk("pend_valid", int'(bus.out_valid), 1);
            chk("pend_keep", int'(bus.out_sym), 24);
            cyc();
        end
        bus.out_ready = 1'b1;
        cyc();
        chk("pend_drain", int'(bus.out_valid), 0);

        // Reset in the middle of a load
        for (int k = 0; k < 6; k++) put_pair(2 * k, 2 * k + 1);
        rst = 1'b1;
        #1;
        chk("midrst_armed", int'(bus.armed), 1);
        chk("midrst_valid", int'(bus.out_valid), 0);
        cyc();
        rst = 1'b0;
        cyc();
        lookup(2, 23, "midrst_sym");
        cyc();

        // Random traffic scored by the model
        for (int c = 0; c < 4000; c++) begin
            idle();
            rst = ($urandom_range(0, 599) == 0);
            bus.cfg_start = ($urandom_range(0, 119) == 0);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_sym    = W'($urandom_range(0, 31));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 1) begin
                bus.cfg_valid = 1'b1;
                free.delete();
                for (int i = 0; i < N; i++)
                    if (!m_paired[i]) free.push_back(i);
                if (free.size() >= 2 && $urandom_range(0, 99) < 97) begin
                    i0 = $urandom_range(0, free.size() - 1);
                    i1 = $urandom_range(0, free.size() - 2);
                    if (i1 >= i0) i1++;
                    bus.cfg_a = W'(free[i0]);
                    bus.cfg_b = W'(free[i1]);
                end else begin
                    bus.cfg_a = W'($urandom_range(0, 31));
                    bus.cfg_b = W'($urandom_range(0, 31));
                end
            end
            cyc();
        end
        rst = 1'b0;
        idle();
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
